// File: rtl/msx50bus_pkg.sv
// Shared types and constants for the MSX-50BUS initiator.
package msx50bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    DONE,
    GAP
  } msx50bus_state_t;

  // Read data returned when no target answered or for writes
  localparam logic [7:0]  MSX50BUS_IDLE_DATA = 8'hFF;
  localparam logic [15:0] MSX50BUS_ADDR_IDLE = 16'h0000;

endpackage

// File: rtl/msx50bus_wait_timer.sv
// Loadable down-counter; expire_o is high while the count sits at 1, i.e. during the
// last cycle of a loaded interval. Shared by the WAIT (timeout) and GAP phases.
module msx50bus_wait_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_value_i,
  input  logic       dec_i,
  output logic       expire_o
);

  logic [7:0] count_q, count_d;

  // Next count: load wins over decrement; saturate at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == 8'd1);

endmodule

// File: rtl/msx50bus_initiator.sv
// MSX-50BUS initiator: one CPU-side request becomes a single-cycle bus strobe, followed by
// an optional read wait (with timeout), a one-cycle response and a fixed idle gap.
// Optional feature: define MSX50BUS_CS_CHECK_EN to complete reads immediately when no target
// asserts the chip select for the addressed space during the strobe.
module msx50bus_initiator
  import msx50bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10,
  parameter int unsigned GAP_CYCLES     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_address,
  input  logic [7:0]  req_wdata,
  input  logic        req_write,
  input  logic        req_io,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_write_data,
  output logic        bus_read,
  output logic        bus_write,
  output logic        bus_io,
  output logic        bus_memory,
  input  logic        bus_read_ready,
  input  logic [7:0]  bus_read_data,
  input  logic        bus_io_cs,
  input  logic        bus_memory_cs
);

  localparam logic [7:0] TimeoutLoad = 8'(TIMEOUT_CYCLES);
  localparam logic [7:0] GapLoad     = 8'(GAP_CYCLES);

  msx50bus_state_t state_q;
  logic        req_ready_q, rsp_valid_q, rsp_timeout_q;
  logic [7:0]  rsp_rdata_q, bus_write_data_q;
  logic [15:0] bus_address_q;
  logic        bus_read_q, bus_write_q, bus_io_q, bus_memory_q;

  logic       cs_ok;
  logic       timer_load, timer_dec, timer_expire;
  logic [7:0] timer_value;

`ifdef MSX50BUS_CS_CHECK_EN
  // Bus qualifiers are only valid during STROBE, which is the only place cs_ok is used
  assign cs_ok = bus_io_q ? bus_io_cs : bus_memory_cs;
`else
  assign cs_ok = 1'b1;
  logic unused_cs;
  assign unused_cs = bus_io_cs ^ bus_memory_cs;
`endif

  // Timer control: arm the timeout when a read enters WAIT, arm the gap when leaving DONE
  always_comb begin
    timer_load  = 1'b0;
    timer_value = TimeoutLoad;
    timer_dec   = 1'b0;
    case (state_q)
      STROBE: timer_load = bus_read_q & cs_ok;
      WAIT:   timer_dec  = 1'b1;
      DONE: begin
        timer_load  = (GapLoad != 8'd0);
        timer_value = GapLoad;
      end
      GAP:    timer_dec  = 1'b1;
      default: ;
    endcase
  end

  msx50bus_wait_timer u_wait_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (timer_load),
    .load_value_i (timer_value),
    .dec_i        (timer_dec),
    .expire_o     (timer_expire)
  );

  // Transaction FSM with registered handshake, response and bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      req_ready_q      <= 1'b1;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= MSX50BUS_IDLE_DATA;
      rsp_timeout_q    <= 1'b0;
      bus_address_q    <= MSX50BUS_ADDR_IDLE;
      bus_write_data_q <= 8'h00;
      bus_read_q       <= 1'b0;
      bus_write_q      <= 1'b0;
      bus_io_q         <= 1'b0;
      bus_memory_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q          <= STROBE;
            req_ready_q      <= 1'b0;
            bus_address_q    <= req_address;
            bus_write_data_q <= req_write ? req_wdata : 8'h00;
            bus_read_q       <= ~req_write;
            bus_write_q      <= req_write;
            bus_io_q         <= req_io;
            bus_memory_q     <= ~req_io;
          end
        end
        STROBE: begin
          bus_address_q    <= MSX50BUS_ADDR_IDLE;
          bus_write_data_q <= 8'h00;
          bus_read_q       <= 1'b0;
          bus_write_q      <= 1'b0;
          bus_io_q         <= 1'b0;
          bus_memory_q     <= 1'b0;
          if (bus_write_q) begin
            state_q       <= DONE;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= MSX50BUS_IDLE_DATA;
            rsp_timeout_q <= 1'b0;
          end else if (!cs_ok) begin
            state_q       <= DONE;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= MSX50BUS_IDLE_DATA;
            rsp_timeout_q <= 1'b1;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus_read_ready) begin
            state_q       <= DONE;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= bus_read_data;
            rsp_timeout_q <= 1'b0;
          end else if (timer_expire) begin
            state_q       <= DONE;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= MSX50BUS_IDLE_DATA;
            rsp_timeout_q <= 1'b1;
          end
        end
        DONE: begin
          if (GapLoad == 8'd0) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (timer_expire) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign bus_address    = bus_address_q;
  assign bus_write_data = bus_write_data_q;
  assign bus_read       = bus_read_q;
  assign bus_write      = bus_write_q;
  assign bus_io         = bus_io_q;
  assign bus_memory     = bus_memory_q;

endmodule

// File: tb/tb_msx50bus_initiator.sv
// Directed bench for msx50bus_initiator with a small PPI target model on the bus.
module tb_msx50bus_initiator;

  localparam int Tmo = 10;
  localparam int Gap = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_address = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        req_write = 1'b0;
  logic        req_io = 1'b0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_read, bus_write, bus_io, bus_memory;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;
  logic        bus_io_cs, bus_memory_cs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  msx50bus_initiator #(
    .TIMEOUT_CYCLES (Tmo),
    .GAP_CYCLES     (Gap)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_address    (req_address),
    .req_wdata      (req_wdata),
    .req_write      (req_write),
    .req_io         (req_io),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_timeout    (rsp_timeout),
    .bus_address    (bus_address),
    .bus_write_data (bus_write_data),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_io         (bus_io),
    .bus_memory     (bus_memory),
    .bus_read_ready (bus_read_ready),
    .bus_read_data  (bus_read_data),
    .bus_io_cs      (bus_io_cs),
    .bus_memory_cs  (bus_memory_cs)
  );

  // PPI model: IO chip select covers 00A8-00AF, ports A8-AB answer one cycle after the strobe
  logic [7:0] primary_slot = 8'h00;
  logic [7:0] key_matrix_column = 8'h9A;
  logic [7:0] port_c = 8'hC3;
  logic       ppi_rdy = 1'b0;
  logic [7:0] ppi_data = 8'h00;
  logic       inj_rdy = 1'b0;

  assign bus_io_cs      = bus_io && (bus_address[15:3] == 13'h0015);
  assign bus_memory_cs  = 1'b0;
  assign bus_read_ready = ppi_rdy | inj_rdy;
  assign bus_read_data  = inj_rdy ? 8'h55 : ppi_data;

  always @(posedge clk) begin
    if (reset) begin
      ppi_rdy <= 1'b0;
    end else begin
      ppi_rdy <= bus_read && bus_io && (bus_address[15:2] == 14'h002A);
      case (bus_address[1:0])
        2'd0:    ppi_data <= primary_slot;
        2'd1:    ppi_data <= key_matrix_column;
        2'd2:    ppi_data <= port_c;
        default: ppi_data <= 8'h00;
      endcase
      if (bus_write && bus_io && bus_address == 16'h00A8) primary_slot <= bus_write_data;
      if (bus_write && bus_io && bus_address == 16'h00AA) port_c <= bus_write_data;
    end
  end

  // Bus tallies, sampled mid-cycle
  int rsp_count = 0;
  int strobe_count = 0;
  int bus_err = 0;
  always @(negedge clk) begin
    if (rsp_valid) rsp_count++;
    if (bus_read || bus_write) strobe_count++;
    if ((bus_read && bus_write) || (bus_io && bus_memory) ||
        ((bus_read | bus_write) != (bus_io | bus_memory)) ||
        (!(bus_read | bus_write) && (bus_address != 16'h0000 || bus_write_data != 8'h00)))
      bus_err++;
  end

  // Strobe-cycle capture from the most recent issue()
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic        s_rd, s_wr, s_io, s_mem;

  // Issue one request from an idle phase (#1 after an edge); returns at the rsp_valid cycle
  task automatic issue(input logic [15:0] a, input logic [7:0] d, input logic w,
                       input logic io, output int lat);
    int n = 0;
    req_address = a; req_wdata = d; req_write = w; req_io = io; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    s_addr = bus_address; s_wdata = bus_write_data;
    s_rd = bus_read; s_wr = bus_write; s_io = bus_io; s_mem = bus_memory;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_req_ready got %b want 1", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    vectors++; if (rsp_rdata !== 8'hFF) begin miscompares++;
      $display("FAIL reset_rsp_rdata got %h want ff", rsp_rdata); end
    vectors++; if (rsp_timeout !== 1'b0) begin miscompares++;
      $display("FAIL reset_rsp_timeout got %b want 0", rsp_timeout); end
    vectors++;
    if ({bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_bus got %h/%h %b%b%b%b want all 0", bus_address, bus_write_data,
               bus_read, bus_write, bus_io, bus_memory);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_io_write();
    int lat, sc;
    sc = strobe_count;
    issue(16'h00A8, 8'h12, 1'b1, 1'b1, lat);
    vectors++; if (s_addr !== 16'h00A8) begin miscompares++;
      $display("FAIL wr_strobe_addr got %h want 00a8", s_addr); end
    vectors++; if ({s_rd, s_wr, s_io, s_mem} !== 4'b0110) begin miscompares++;
      $display("FAIL wr_strobe_qual got %b want 0110", {s_rd, s_wr, s_io, s_mem}); end
    vectors++; if (s_wdata !== 8'h12) begin miscompares++;
      $display("FAIL wr_strobe_data got %h want 12", s_wdata); end
    vectors++; if (lat !== 2) begin miscompares++;
      $display("FAIL wr_latency got %0d want 2", lat); end
    vectors++; if (rsp_timeout !== 1'b0 || rsp_rdata !== 8'hFF) begin miscompares++;
      $display("FAIL wr_rsp got %b/%h want 0/ff", rsp_timeout, rsp_rdata); end
    vectors++; if (primary_slot !== 8'h12) begin miscompares++;
      $display("FAIL wr_primary_slot got %h want 12", primary_slot); end
    vectors++; if (strobe_count - sc !== 1) begin miscompares++;
      $display("FAIL wr_strobe_count got %0d want 1", strobe_count - sc); end
  endtask

  task automatic test_io_read();
    int lat;
    issue(16'h00A9, 8'h77, 1'b0, 1'b1, lat);
    vectors++; if ({s_rd, s_wr, s_io, s_mem} !== 4'b1010 || s_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL rd_strobe got %b/%h want 1010/00", {s_rd, s_wr, s_io, s_mem}, s_wdata);
    end
    vectors++; if (lat !== 3) begin miscompares++;
      $display("FAIL rd_latency got %0d want 3", lat); end
    vectors++; if (rsp_rdata !== 8'h9A || rsp_timeout !== 1'b0) begin miscompares++;
      $display("FAIL rd_rsp got %h/%b want 9a/0", rsp_rdata, rsp_timeout); end
    vectors++;
    if ({bus_address, bus_read, bus_write, bus_io, bus_memory} !== 20'h0) begin
      miscompares++;
      $display("FAIL rd_bus_after got %h %b%b%b%b want 0", bus_address, bus_read, bus_write,
               bus_io, bus_memory);
    end
    repeat (Gap + 1) @(posedge clk);
    #1;
  endtask

  task automatic test_mem_timeout();
    int lat, want;
`ifdef MSX50BUS_CS_CHECK_EN
    want = 2;
`else
    want = 2 + Tmo;
`endif
    issue(16'h00A8, 8'h00, 1'b0, 1'b0, lat);
    vectors++; if ({s_rd, s_wr, s_io, s_mem} !== 4'b1001) begin miscompares++;
      $display("FAIL mem_strobe_qual got %b want 1001", {s_rd, s_wr, s_io, s_mem}); end
    vectors++; if (lat !== want) begin miscompares++;
      $display("FAIL mem_timeout_latency got %0d want %0d", lat, want); end
    vectors++; if (rsp_rdata !== 8'hFF || rsp_timeout !== 1'b1) begin miscompares++;
      $display("FAIL mem_timeout_rsp got %h/%b want ff/1", rsp_rdata, rsp_timeout); end
    repeat (Gap + 1) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int acc[4], rsp[4], str[4];
    int na = 0, nr = 0, ns = 0;
    req_address = 16'h00A8; req_write = 1'b1; req_io = 1'b1; req_wdata = 8'h01;
    req_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic hit;
      hit = req_valid && req_ready;
      if (hit && na < 4) begin acc[na] = k; na++; end
      if (rsp_valid && nr < 4) begin rsp[nr] = k; nr++; end
      if (bus_write && ns < 4) begin str[ns] = k; ns++; end
      @(posedge clk); #1;
      if (hit) req_wdata = 8'(na + 1);
      if (na == 4) req_valid = 1'b0;
    end
    vectors++; if (na !== 4 || nr !== 4 || ns !== 4) begin miscompares++;
      $display("FAIL b2b_counts got acc=%0d rsp=%0d strobe=%0d want 4/4/4", na, nr, ns); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (acc[i+1] - rsp[i] !== Gap + 1) begin miscompares++;
        $display("FAIL b2b_gap[%0d] got %0d want %0d", i, acc[i+1] - rsp[i], Gap + 1); end
      vectors++; if (str[i+1] - str[i] !== Gap + 3) begin miscompares++;
        $display("FAIL b2b_strobe_spacing[%0d] got %0d want %0d", i, str[i+1] - str[i],
                 Gap + 3); end
    end
    vectors++; if (rsp[0] - acc[0] !== 2) begin miscompares++;
      $display("FAIL b2b_first_latency got %0d want 2", rsp[0] - acc[0]); end
    vectors++; if (primary_slot !== 8'h04) begin miscompares++;
      $display("FAIL b2b_last_data got %h want 04", primary_slot); end
  endtask

  task automatic test_gap_ready();
    int lat, rc;
    issue(16'h00A9, 8'h00, 1'b0, 1'b1, lat);
    vectors++; if (rsp_rdata !== 8'h9A) begin miscompares++;
      $display("FAIL gap_pre_read got %h want 9a", rsp_rdata); end
    @(posedge clk); #1;
    rc = rsp_count;
    inj_rdy = 1'b1;
    for (int g = 0; g < Gap; g++) begin
      vectors++; if (req_ready !== 1'b0) begin miscompares++;
        $display("FAIL gap_req_ready[%0d] got %b want 0", g, req_ready); end
      @(posedge clk); #1;
      if (g == Gap - 2) inj_rdy = 1'b0;
    end
    inj_rdy = 1'b0;
    vectors++; if (req_ready !== 1'b1) begin miscompares++;
      $display("FAIL gap_end_ready got %b want 1", req_ready); end
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (rsp_count !== rc) begin miscompares++;
      $display("FAIL gap_spurious_rsp got %0d want %0d", rsp_count, rc); end
    vectors++; if (rsp_rdata !== 8'h9A) begin miscompares++;
      $display("FAIL gap_rdata_held got %h want 9a", rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    int lat, rc, n = 0;
    req_address = 16'h00AC; req_write = 1'b0; req_io = 1'b1; req_valid = 1'b1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rc = rsp_count;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++;
      $display("FAIL rstmid_handshake got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    vectors++; if (rsp_rdata !== 8'hFF) begin miscompares++;
      $display("FAIL rstmid_rdata got %h want ff", rsp_rdata); end
    repeat (Tmo + 5) @(posedge clk);
    #1;
    vectors++; if (rsp_count !== rc) begin miscompares++;
      $display("FAIL rstmid_no_rsp got %0d want %0d", rsp_count, rc); end
    issue(16'h00AA, 8'h00, 1'b0, 1'b1, lat);
    vectors++; if (lat !== 3 || rsp_rdata !== 8'hC3 || rsp_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_next_read got lat=%0d %h/%b want 3 c3/0", lat, rsp_rdata,
               rsp_timeout);
    end
    repeat (Gap + 1) @(posedge clk);
    #1;
  endtask

  task automatic test_bus_invariants();
    vectors++; if (bus_err !== 0) begin miscompares++;
      $display("FAIL bus_invariants got %0d bad cycles want 0", bus_err); end
  endtask

  initial begin
    test_reset();
    test_io_write();
    repeat (Gap + 1) @(posedge clk);
    #1;
    test_io_read();
    test_mem_timeout();
    test_back_to_back();
    test_gap_ready();
    test_reset_mid();
    test_bus_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
